// File: rtl/execute_cycle_if.sv
// ID/EX-to-EX/MEM bundle of the execute stage: decoded operands and control in,
// branch redirect and EX/MEM register contents out.
interface execute_cycle_if;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] ImmExtE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [4:0]  RdE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        JumpE;
  logic        jalrE;
  logic        BranchE;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [1:0]  ResultSrcE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [31:0] ResultW;

  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;

  // Upstream side: decode/hazard logic drives operands, consumes the results.
  modport master (
    output RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, RdE,
    output RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE,
    output ALUControlE, ResultSrcE, ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M,
    input  RdM, RegWriteM, MemWriteM, ResultSrcM
  );

  // Execute stage side.
  modport slave (
    input  RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, RdE,
    input  RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE,
    input  ALUControlE, ResultSrcE, ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M,
    output RdM, RegWriteM, MemWriteM, ResultSrcM
  );
endinterface

// File: rtl/execute_cycle.sv
// RISC-V execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register feeding the memory stage.
module execute_cycle (
  input  logic            clk,
  input  logic            rst,
  execute_cycle_if.slave  ex
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  logic [31:0] aluResultMReg;
  logic [31:0] writeDataMReg;
  logic [31:0] pcPlus4MReg;
  logic [4:0]  rdMReg;
  logic        regWriteMReg;
  logic        memWriteMReg;
  logic [1:0]  resultSrcMReg;

  logic [31:0] srcA;
  logic [31:0] writeData;
  logic [31:0] srcB;
  logic [31:0] aluResult;
  logic [31:0] jalrSum;
  logic [31:0] pcTarget;
  logic        zero;
  logic        signedLess;

  // Forwarding from ALUResultM uses this stage's own register, so a back-to-back
  // dependency sees the previous edge's result with no extra cycle.
  always_comb begin
    srcA = ex.RD1_E;
    case (ex.ForwardAE)
      2'b01:   srcA = ex.ResultW;
      2'b10:   srcA = aluResultMReg;
      default: srcA = ex.RD1_E;
    endcase
  end

  always_comb begin
    writeData = ex.RD2_E;
    case (ex.ForwardBE)
      2'b01:   writeData = ex.ResultW;
      2'b10:   writeData = aluResultMReg;
      default: writeData = ex.RD2_E;
    endcase
  end

  assign srcB       = ex.ALUSrcE ? ex.ImmExtE : writeData;
  assign signedLess = ($signed(srcA) < $signed(srcB));

  always_comb begin
    aluResult = 32'd0;
    case (ex.ALUControlE)
      ALU_ADD: aluResult = srcA + srcB;
      ALU_SUB: aluResult = srcA - srcB;
      ALU_AND: aluResult = srcA & srcB;
      ALU_OR:  aluResult = srcA | srcB;
      ALU_XOR: aluResult = srcA ^ srcB;
      ALU_SLT: aluResult = {31'd0, signedLess};
      ALU_SLL: aluResult = srcA << srcB[4:0];
      ALU_SRL: aluResult = srcA >> srcB[4:0];
      default: aluResult = 32'd0;
    endcase
  end

  assign zero    = (aluResult == 32'd0);
  assign jalrSum = srcA + ex.ImmExtE;

  // jalr targets are register-relative with the LSB forced to zero.
  assign pcTarget = ex.jalrE ? {jalrSum[31:1], 1'b0} : (ex.PCE + ex.ImmExtE);

  assign ex.PCTargetE = pcTarget;
  assign ex.PCSrcE    = ex.JumpE | ex.jalrE | (ex.BranchE & zero);

  // EX/MEM register; store data is the forwarded RD2, never the immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluResultMReg <= 32'd0;
      writeDataMReg <= 32'd0;
      pcPlus4MReg   <= 32'd0;
      rdMReg        <= 5'd0;
      regWriteMReg  <= 1'b0;
      memWriteMReg  <= 1'b0;
      resultSrcMReg <= 2'd0;
    end else begin
      aluResultMReg <= aluResult;
      writeDataMReg <= writeData;
      pcPlus4MReg   <= ex.PCPlus4E;
      rdMReg        <= ex.RdE;
      regWriteMReg  <= ex.RegWriteE;
      memWriteMReg  <= ex.MemWriteE;
      resultSrcMReg <= ex.ResultSrcE;
    end
  end

  assign ex.ALUResultM = aluResultMReg;
  assign ex.WriteDataM = writeDataMReg;
  assign ex.PCPlus4M   = pcPlus4MReg;
  assign ex.RdM        = rdMReg;
  assign ex.RegWriteM  = regWriteMReg;
  assign ex.MemWriteM  = memWriteMReg;
  assign ex.ResultSrcM = resultSrcMReg;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed scenarios plus randomized traffic
// against a behavioural model of the execute stage.
module tb_execute_cycle;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Model of the EX/MEM register contents.
  logic [31:0] expAluM, expWdM, expPc4M;
  logic [4:0]  expRdM;
  logic        expRegWM, expMemWM;
  logic [1:0]  expResSrcM;

  execute_cycle_if bus ();

  execute_cycle dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd);
    if (sel == 2'd1) return bus.ResultW;
    if (sel == 2'd2) return expAluM;
    return rd;
  endfunction

  function automatic logic [31:0] modelSrcA();
    return fwd(bus.ForwardAE, bus.RD1_E);
  endfunction

  function automatic logic [31:0] modelWd();
    return fwd(bus.ForwardBE, bus.RD2_E);
  endfunction

  function automatic logic [31:0] modelAlu();
    logic [31:0] b;
    b = bus.ALUSrcE ? bus.ImmExtE : modelWd();
    return refAlu(bus.ALUControlE, modelSrcA(), b);
  endfunction

  function automatic logic modelPcSrc();
    return bus.JumpE | bus.jalrE | (bus.BranchE & (modelAlu() == 32'd0));
  endfunction

  function automatic logic [31:0] modelTarget();
    logic [31:0] s;
    if (bus.jalrE) begin
      s = modelSrcA() + bus.ImmExtE;
      return s & 32'hFFFF_FFFE;
    end
    return bus.PCE + bus.ImmExtE;
  endfunction

  task automatic clearModel();
    expAluM = 0; expWdM = 0; expPc4M = 0; expRdM = 0;
    expRegWM = 0; expMemWM = 0; expResSrcM = 0;
  endtask

  // Advance one clock and update the model with what the stage should capture.
  task automatic tick();
    logic [31:0] r, wd;
    r  = modelAlu();
    wd = modelWd();
    @(posedge clk);
    if (rst) clearModel();
    else begin
      expAluM = r; expWdM = wd; expPc4M = bus.PCPlus4E; expRdM = bus.RdE;
      expRegWM = bus.RegWriteE; expMemWM = bus.MemWriteE; expResSrcM = bus.ResultSrcE;
    end
    #1;
  endtask

  task automatic idle();
    bus.RD1_E = 0; bus.RD2_E = 0; bus.ImmExtE = 0; bus.PCE = 0; bus.PCPlus4E = 0;
    bus.RdE = 0; bus.RegWriteE = 0; bus.MemWriteE = 0; bus.JumpE = 0; bus.jalrE = 0;
    bus.BranchE = 0; bus.ALUSrcE = 0; bus.ALUControlE = 0; bus.ResultSrcE = 0;
    bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = 0;
  endtask

  task automatic test_reset();
    logic [31:0] live;
    idle();
    #1;
    checks++;
    if ({bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M, bus.RdM, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM} !== '0) begin
      errors++;
      $display("FAIL reset_initial: ALUResultM=%h RegWriteM=%b required all zero", bus.ALUResultM, bus.RegWriteM);
    end
    rst = 1'b0;
    bus.RegWriteE = 1; bus.RD1_E = 5; bus.RD2_E = 3; bus.RdE = 5'd7; bus.PCPlus4E = 32'h44; bus.ResultSrcE = 2'd1;
    tick();
    checks++;
    if (bus.RegWriteM !== 1'b1 || bus.ALUResultM !== 32'd8 || bus.RdM !== 5'd7) begin
      errors++;
      $display("FAIL reset_prerun: RegWriteM=%b ALUResultM=%h RdM=%0d required 1/00000008/7", bus.RegWriteM, bus.ALUResultM, bus.RdM);
    end
    #2 rst = 1'b1;
    #1;
    clearModel();
    checks++;
    if ({bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M, bus.RdM, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM} !== '0) begin
      errors++;
      $display("FAIL reset_async: ALUResultM=%h PCPlus4M=%h RegWriteM=%b required all zero", bus.ALUResultM, bus.PCPlus4M, bus.RegWriteM);
    end
    // ALUResultM-forwarded operand reads as zero while in reset; seen via jalr target.
    bus.ForwardAE = 2'b10; bus.jalrE = 1; bus.ImmExtE = 32'h10;
    #1;
    checks++;
    if (bus.PCTargetE !== 32'h10 || bus.PCSrcE !== 1'b1) begin
      errors++;
      $display("FAIL reset_fwd_zero: PCTargetE=%h PCSrcE=%b required 00000010/1", bus.PCTargetE, bus.PCSrcE);
    end
    tick();
    bus.ForwardAE = 0; bus.jalrE = 0; bus.ImmExtE = 0;
    #2 rst = 1'b0;
    live = modelAlu();
    tick();
    checks++;
    if (bus.ALUResultM !== live || bus.ALUResultM !== 32'd8) begin
      errors++;
      $display("FAIL reset_release: ALUResultM=%h required %h", bus.ALUResultM, live);
    end
  endtask

  task automatic test_alu_sweep();
    logic [31:0] table_ [8];
    table_ = '{32'h0000_0000, 32'hFFFF_FFE0, 32'h0000_0010, 32'hFFFF_FFF0,
               32'hFFFF_FFE0, 32'h0000_0001, 32'hFFF0_0000, 32'h0000_FFFF};
    for (int op = 0; op < 8; op++) begin
      idle();
      bus.RD1_E = 32'hFFFF_FFF0; bus.RD2_E = 32'h0000_0010; bus.ALUControlE = 3'(op);
      tick();
      checks++;
      if (bus.ALUResultM !== table_[op]) begin
        errors++;
        $display("FAIL alu_op%0d: ALUResultM=%h required %h", op, bus.ALUResultM, table_[op]);
      end
    end
  endtask

  task automatic test_forwarding();
    idle();
    bus.RD1_E = 1; bus.RD2_E = 2;
    tick();
    checks++;
    if (bus.ALUResultM !== 32'd3) begin
      errors++;
      $display("FAIL fwd_setup: ALUResultM=%h required 00000003", bus.ALUResultM);
    end
    bus.RD1_E = 0; bus.RD2_E = 0; bus.ForwardAE = 2'b10; bus.ForwardBE = 2'b01; bus.ResultW = 7;
    tick();
    checks++;
    if (bus.ALUResultM !== 32'd10 || bus.WriteDataM !== 32'd7) begin
      errors++;
      $display("FAIL fwd_b2b: ALUResultM=%h WriteDataM=%h required 0000000a/00000007", bus.ALUResultM, bus.WriteDataM);
    end
    idle();
    bus.ALUSrcE = 1; bus.ImmExtE = 32'h40; bus.RD1_E = 1; bus.RD2_E = 32'h99; bus.MemWriteE = 1;
    tick();
    checks++;
    if (bus.ALUResultM !== 32'h41 || bus.WriteDataM !== 32'h99 || bus.MemWriteM !== 1'b1) begin
      errors++;
      $display("FAIL store_data: ALUResultM=%h WriteDataM=%h MemWriteM=%b required 00000041/00000099/1",
               bus.ALUResultM, bus.WriteDataM, bus.MemWriteM);
    end
  endtask

  task automatic test_branch();
    idle();
    bus.BranchE = 1; bus.ALUControlE = 3'b001; bus.RD1_E = 32'h55; bus.RD2_E = 32'h55;
    bus.PCE = 32'h100; bus.ImmExtE = 32'hFFFF_FFF8;
    #1;
    checks++;
    if (bus.PCSrcE !== 1'b1 || bus.PCTargetE !== 32'hF8) begin
      errors++;
      $display("FAIL branch_taken: PCSrcE=%b PCTargetE=%h required 1/000000f8", bus.PCSrcE, bus.PCTargetE);
    end
    bus.RD2_E = 32'h56;
    #1;
    checks++;
    if (bus.PCSrcE !== 1'b0) begin
      errors++;
      $display("FAIL branch_not_taken: PCSrcE=%b required 0", bus.PCSrcE);
    end
    tick();
  endtask

  task automatic test_jalr();
    idle();
    bus.jalrE = 1; bus.RD1_E = 32'h1003; bus.ImmExtE = 32'd4;
    #1;
    checks++;
    if (bus.PCTargetE !== 32'h1006 || bus.PCSrcE !== 1'b1) begin
      errors++;
      $display("FAIL jalr: PCTargetE=%h PCSrcE=%b required 00001006/1", bus.PCTargetE, bus.PCSrcE);
    end
    tick();
  endtask

  task automatic test_jal();
    idle();
    bus.JumpE = 1; bus.PCE = 32'h200; bus.ImmExtE = 32'h20; bus.PCPlus4E = 32'h204;
    bus.ResultSrcE = 2'b10; bus.RegWriteE = 1; bus.RdE = 5'd1;
    #1;
    checks++;
    if (bus.PCTargetE !== 32'h220 || bus.PCSrcE !== 1'b1) begin
      errors++;
      $display("FAIL jal_target: PCTargetE=%h PCSrcE=%b required 00000220/1", bus.PCTargetE, bus.PCSrcE);
    end
    tick();
    checks++;
    if (bus.PCPlus4M !== 32'h204 || bus.ResultSrcM !== 2'b10 || bus.RdM !== 5'd1) begin
      errors++;
      $display("FAIL jal_link: PCPlus4M=%h ResultSrcM=%b RdM=%0d required 00000204/10/1", bus.PCPlus4M, bus.ResultSrcM, bus.RdM);
    end
  endtask

  task automatic test_random();
    logic        ePcSrc;
    logic [31:0] eTarget;
    for (int i = 0; i < 300; i++) begin
      bus.RD1_E = $urandom; bus.RD2_E = ($urandom_range(0, 3) == 0) ? bus.RD1_E : $urandom;
      bus.ImmExtE = $urandom; bus.PCE = $urandom; bus.PCPlus4E = $urandom; bus.ResultW = $urandom;
      bus.RdE = 5'($urandom); bus.RegWriteE = 1'($urandom); bus.MemWriteE = 1'($urandom);
      bus.JumpE = ($urandom_range(0, 5) == 0); bus.jalrE = ($urandom_range(0, 5) == 0);
      bus.BranchE = 1'($urandom); bus.ALUSrcE = 1'($urandom); bus.ALUControlE = 3'($urandom);
      bus.ResultSrcE = 2'($urandom); bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
      if (bus.ALUControlE == 3'd7 && $urandom_range(0, 1) == 0) bus.RD1_E = 0;
      #1;
      ePcSrc  = modelPcSrc();
      eTarget = modelTarget();
      checks++;
      if (bus.PCSrcE !== ePcSrc || bus.PCTargetE !== eTarget) begin
        errors++;
        $display("FAIL rand_comb[%0d]: PCSrcE=%b PCTargetE=%h required %b/%h", i, bus.PCSrcE, bus.PCTargetE, ePcSrc, eTarget);
      end
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        #1;
        clearModel();
        tick();
        #2 rst = 1'b0;
      end else begin
        tick();
      end
      checks++;
      if (bus.ALUResultM !== expAluM || bus.WriteDataM !== expWdM || bus.PCPlus4M !== expPc4M ||
          bus.RdM !== expRdM || bus.RegWriteM !== expRegWM || bus.MemWriteM !== expMemWM ||
          bus.ResultSrcM !== expResSrcM) begin
        errors++;
        $display("FAIL rand_reg[%0d]: ALU=%h WD=%h PC4=%h Rd=%0d RW=%b MW=%b RS=%b required %h %h %h %0d %b %b %b",
                 i, bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M, bus.RdM, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM,
                 expAluM, expWdM, expPc4M, expRdM, expRegWM, expMemWM, expResSrcM);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clearModel();
    test_reset();
    test_alu_sweep();
    test_forwarding();
    test_branch();
    test_jalr();
    test_jal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
